// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring signed divider, one quotient bit per clock, fixed latency
module seq_divider #(
  parameter int Width_dividend = 32,
  parameter int Width_divisor  = 16,
  parameter int Width_count    = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld,
  input  logic [Width_dividend-1:0] in_dividend,
  input  logic [Width_divisor-1:0]  in_divisor,
  output logic                      busy,
  output logic                      ld_q,
  output logic [Width_dividend-1:0] quotient,
  output logic [Width_divisor-1:0]  remainder,
  output logic                      div_by_zero
);
  typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;
  state_t                    r_state, w_next;
  logic [Width_count-1:0]    r_cnt;
  logic [Width_dividend-1:0] r_dvd, r_quo;
  logic [Width_divisor-1:0]  r_dvs, r_dvs_mag, r_rem;
  logic [Width_divisor:0]    w_sh, w_diff;
  logic                      w_ge, w_last, w_zero;
  logic [Width_dividend-1:0] w_dvd_mag, w_q;
  logic [Width_divisor-1:0]  w_dvs_mag, w_r;
  assign busy      = r_state != IDLE;
  assign w_last    = r_cnt == Width_count'(Width_dividend - 1);
  assign w_zero    = r_dvs == '0;
  assign w_dvd_mag = r_dvd[Width_dividend-1] ? -r_dvd : r_dvd;
  assign w_dvs_mag = r_dvs[Width_divisor-1] ? -r_dvs : r_dvs;
  assign w_sh      = {r_rem, r_quo[Width_dividend-1]};
  assign w_diff    = w_sh - {1'b0, r_dvs_mag};
  assign w_ge      = w_sh >= {1'b0, r_dvs_mag};
  assign w_q       = (r_dvd[Width_dividend-1] ^ r_dvs[Width_divisor-1]) ? -r_quo : r_quo;
  assign w_r       = r_dvd[Width_dividend-1] ? -r_rem : r_rem;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // next-state: accept in IDLE, one prep cycle, Width_dividend shift steps, one fix-up cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ld ? PREP : IDLE;
      PREP:    w_next = DIV;
      DIV:     w_next = w_last ? FIX : DIV;
      default: w_next = IDLE;
    endcase
  end
  // datapath: operand capture, magnitude iteration, sign fix-up and result registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_dvs_mag   <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      ld_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      ld_q <= 1'b0;
      case (r_state)
        IDLE: if (ld) begin
          r_dvd <= in_dividend;
          r_dvs <= in_divisor;
        end
        PREP: begin
          r_quo     <= w_dvd_mag;
          r_dvs_mag <= w_dvs_mag;
          r_rem     <= '0;
          r_cnt     <= '0;
        end
        DIV: begin
          r_rem <= Width_divisor'(w_ge ? w_diff : w_sh);
          r_quo <= {r_quo[Width_dividend-2:0], w_ge};
          r_cnt <= r_cnt + Width_count'(1);
        end
        default: begin
          quotient    <= w_zero ? '1 : w_q;
          remainder   <= w_zero ? r_dvd[Width_divisor-1:0] : w_r;
          div_by_zero <= w_zero;
          ld_q        <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table vectors, busy/reset corner sequences and randomized back-to-back checks
module tb_seq_divider;
  logic        clk = 1'b0, reset, ld, busy, ld_q, div_by_zero;
  logic [31:0] in_dividend, quotient;
  logic [15:0] in_divisor, remainder;
  int          errors = 0, checks = 0, starts = 0, pulses = 0;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
  } vec_t;
  vec_t vecs[9];

  seq_divider dut (
    .clk(clk), .reset(reset), .ld(ld), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .busy(busy), .ld_q(ld_q), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ld_q) pulses++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [15:0] b);
    in_dividend = a;
    in_divisor  = b;
    ld = 1'b1;
    starts++;
    @(posedge clk);
    #1 ld = 1'b0;
    chk("busy_after_ld", 64'(busy), 64'd1);
  endtask

  task automatic finish_op(input string tag, input int lat0, input logic [31:0] q,
                           input logic [15:0] r, input logic z);
    int lat = lat0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!ld_q && lat < 40);
    chk({tag, "_latency"}, 64'(lat), 64'd34);
    chk({tag, "_quotient"}, 64'(quotient), 64'(q));
    chk({tag, "_remainder"}, 64'(remainder), 64'(r));
    chk({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(z));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r, output logic z);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    z = (sb == 0);
    q = z ? 32'hFFFF_FFFF : 32'(sa / sb);
    r = z ? a[15:0] : 16'(sa % sb);
  endfunction

  initial begin
    vecs[0] = '{32'd100, 16'd7, 32'd14, 16'd2, 1'b0};
    vecs[1] = '{-32'sd100, 16'd7, 32'hFFFF_FFF2, 16'hFFFE, 1'b0};
    vecs[2] = '{32'd100, -16'sd7, 32'hFFFF_FFF2, 16'd2, 1'b0};
    vecs[3] = '{32'h1234_5678, 16'd0, 32'hFFFF_FFFF, 16'h5678, 1'b1};
    vecs[4] = '{32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0, 1'b0};
    vecs[5] = '{32'h8000_0000, 16'h8000, 32'h0001_0000, 16'd0, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 16'h7FFF, 32'h0001_0002, 16'd1, 1'b0};
    vecs[7] = '{32'd7, 16'd100, 32'd0, 16'd7, 1'b0};
    vecs[8] = '{32'd0, -16'sd5, 32'd0, 16'd0, 1'b0};
    reset = 1'b1; ld = 1'b0; in_dividend = '0; in_divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_flags", 64'({busy, ld_q, div_by_zero}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      start(vecs[i].a, vecs[i].b);
      finish_op($sformatf("vec%0d", i), 0, vecs[i].q, vecs[i].r, vecs[i].z);
    end
    start(32'd100, 16'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    in_dividend = 32'd9; in_divisor = 16'd3; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    finish_op("ld_while_busy", 10, 32'd14, 16'd2, 1'b0);
    @(posedge clk);
    #1;
    start(32'd100, 16'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    in_dividend = 32'd9; in_divisor = 16'd3; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_flags", 64'({busy, ld_q, div_by_zero}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    begin
      int seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1 if (ld_q) seen++;
      end
      chk("abort_no_ld_q", 64'(seen), 64'd0);
    end
    starts--;
    start(32'd9, 16'd3);
    finish_op("after_abort", 0, 32'd3, 16'd0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, q;
      logic [15:0] b, r;
      logic        z;
      a = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0: b = 16'd0;
        1: b = 16'h8000;
        2: b = 16'hFFFF;
        3: b = 16'($signed(8'($urandom)));
        default: b = 16'($urandom);
      endcase
      ref_div(a, b, q, r, z);
      start(a, b);
      finish_op($sformatf("rand%0d", i), 0, q, r, z);
      if (!z && !(a == 32'h8000_0000 && b == 16'hFFFF))
        chk($sformatf("rand%0d_invariant", i),
            64'(longint'($signed(quotient)) * longint'($signed(in_divisor))
                + longint'($signed(remainder))),
            64'(longint'($signed(in_dividend))));
    end
    @(posedge clk);
    #1;
    chk("ld_q_pulse_count", 64'(pulses), 64'(starts));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
